// File: rtl/atm_session_guard.sv
// ATM session guard: drives one inactivity/warning timer and turns its
// time_out flag into session warning and expiry events.
module atm_session_guard #(
   parameter logic [31:0] INACT_CYC = 32'd1500,
   parameter logic [31:0] WARN_CYC  = 32'd500,
   parameter int          CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             card_in,
   input  logic             activity,
   input  logic             session_end,
   input  logic             time_out,
   output logic             tmr_start,
   output logic             tmr_restart,
   output logic [31:0]      tmr_threshold,
   output logic             tmr_clr_n,
   output logic             warn_prompt,
   output logic             session_active,
   output logic             session_expired,
   output logic [CNT_W-1:0] expire_count
);

   typedef enum logic [2:0] {
      IDLE, ARM_A, ACTIVE, ARM_W, WARN, EXPIRE, END_CLR
   } state_t;

   state_t state, nxt;
   logic   card_q;
   logic   card_rise, card_fall, quit, to_ok, restart_nxt;

   assign card_rise = card_in & ~card_q;
   assign card_fall = ~card_in & card_q;
   assign quit      = session_end | card_fall;
   // A cleared timer may still show the previous phase's sticky flag.
   assign to_ok     = time_out & tmr_clr_n;

   always_comb begin
      nxt         = state;
      restart_nxt = 1'b0;
      unique case (state)
         IDLE:    if (card_rise) nxt = ARM_A;
         ARM_A:   nxt = ACTIVE;
         ACTIVE: begin
            if (quit)          nxt = END_CLR;
            else if (to_ok)    nxt = ARM_W;
            else if (activity) restart_nxt = 1'b1;
         end
         ARM_W:   nxt = WARN;
         WARN: begin
            if (quit)          nxt = END_CLR;
            else if (to_ok)    nxt = EXPIRE;
            else if (activity) nxt = ARM_A;
         end
         EXPIRE:  nxt = END_CLR;
         END_CLR: nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         card_q          <= 1'b1;
         tmr_start       <= 1'b0;
         tmr_restart     <= 1'b0;
         tmr_threshold   <= '0;
         tmr_clr_n       <= 1'b1;
         warn_prompt     <= 1'b0;
         session_active  <= 1'b0;
         session_expired <= 1'b0;
         expire_count    <= '0;
      end else begin
         state           <= nxt;
         card_q          <= card_in;
         tmr_start       <= 1'b0;
         tmr_restart     <= restart_nxt;
         tmr_threshold   <= '0;
         tmr_clr_n       <= 1'b1;
         warn_prompt     <= 1'b0;
         session_active  <= 1'b0;
         session_expired <= 1'b0;
         unique case (nxt)
            ARM_A: begin
               tmr_clr_n     <= 1'b0;
               tmr_threshold <= INACT_CYC;
            end
            ACTIVE: begin
               tmr_start      <= 1'b1;
               tmr_threshold  <= INACT_CYC;
               session_active <= 1'b1;
            end
            ARM_W: begin
               tmr_clr_n      <= 1'b0;
               tmr_threshold  <= WARN_CYC;
               session_active <= 1'b1;
            end
            WARN: begin
               tmr_start      <= 1'b1;
               tmr_threshold  <= WARN_CYC;
               warn_prompt    <= 1'b1;
               session_active <= 1'b1;
            end
            EXPIRE: begin
               session_expired <= 1'b1;
               if (~&expire_count)
                  expire_count <= expire_count + 1'b1;
            end
            END_CLR: tmr_clr_n <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_atm_session_guard.sv
// Bench for atm_session_guard: phase-level model checked every cycle,
// plus literal expectations along a directed session script.
module tb_atm_session_guard;

   logic        clk = 0;
   logic        rst = 1;
   logic        card_in = 0, activity = 0, session_end = 0, time_out = 0;
   logic        tmr_start, tmr_restart, tmr_clr_n;
   logic [31:0] tmr_threshold;
   logic        warn_prompt, session_active, session_expired;
   logic [7:0]  expire_count;

   int checks = 0;
   int errors = 0;
   bit en = 0;

   atm_session_guard dut (
      .clk(clk), .rst(rst), .card_in(card_in), .activity(activity),
      .session_end(session_end), .time_out(time_out),
      .tmr_start(tmr_start), .tmr_restart(tmr_restart),
      .tmr_threshold(tmr_threshold), .tmr_clr_n(tmr_clr_n),
      .warn_prompt(warn_prompt), .session_active(session_active),
      .session_expired(session_expired), .expire_count(expire_count)
   );

   always #5 clk = ~clk;

   // Phase model: 0 idle,1 clear-before-active,2 active,3 clear-before-warn,
   // 4 warn,5 expired,6 ending
   int ph = 0;
   int m_cnt = 0;
   bit m_card = 1;
   bit m_rs = 0;
   bit rise, fall;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         ph = 0; m_cnt = 0; m_card = 1; m_rs = 0;
      end else begin
         rise = card_in && !m_card;
         fall = !card_in && m_card;
         m_rs = 0;
         case (ph)
            0: if (rise) ph = 1;
            1: ph = 2;
            2: if (session_end || fall) ph = 6;
               else if (time_out) ph = 3;
               else if (activity) m_rs = 1;
            3: ph = 4;
            4: if (session_end || fall) ph = 6;
               else if (time_out) begin
                  ph = 5;
                  if (m_cnt < 255) m_cnt++;
               end else if (activity) ph = 1;
            5: ph = 6;
            default: ph = 0;
         endcase
         m_card = card_in;
      end
   end

   function automatic logic [45:0] expect_vec();
      logic [31:0] thr;
      thr = (ph == 1 || ph == 2) ? 32'd1500 :
            (ph == 3 || ph == 4) ? 32'd500 : 32'd0;
      return {ph == 2 || ph == 4, m_rs, thr,
              !(ph == 1 || ph == 3 || ph == 6), ph == 4,
              ph == 2 || ph == 3 || ph == 4, ph == 5, m_cnt[7:0]};
   endfunction

   always @(negedge clk) if (en) begin
      logic [45:0] got, exp;
      got = {tmr_start, tmr_restart, tmr_threshold, tmr_clr_n,
             warn_prompt, session_active, session_expired, expire_count};
      exp = expect_vec();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL cycle_model t=%0t got=%h want=%h", $time, got, exp);
      end
   end

   task automatic lit(string name, logic [31:0] act, logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", name, act, want);
      end
   endtask

   task automatic cyc(int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_session();
      card_in = 0; cyc();
      card_in = 1; cyc(2);
   endtask

   task automatic expire_once();
      start_session();
      time_out = 1; cyc(3);
      time_out = 0; cyc(2);
   endtask

   initial begin
      #1 rst = 0;
      card_in = 1;
      cyc(2);
      en = 1;
      lit("reset_clr_n", tmr_clr_n, 1);
      lit("reset_thr", tmr_threshold, 0);
      rst = 1;
      cyc(3);
      lit("held_card_idle", session_active, 0);

      card_in = 0; cyc();
      card_in = 1; cyc();
      lit("arm_a_clr_n", tmr_clr_n, 0);
      cyc();
      lit("active_start", tmr_start, 1);
      lit("active_thr", tmr_threshold, 1500);
      lit("active_flag", session_active, 1);

      activity = 1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         lit("restart_pulse", tmr_restart, 1);
      end
      activity = 0; cyc();
      lit("restart_end", tmr_restart, 0);

      time_out = 1; cyc();
      lit("arm_w_clr_n", tmr_clr_n, 0);
      lit("arm_w_warn", warn_prompt, 0);
      cyc();
      lit("warn_prompt", warn_prompt, 1);
      lit("warn_thr", tmr_threshold, 500);
      time_out = 0; activity = 1; cyc();
      lit("recover_clr_n", tmr_clr_n, 0);
      activity = 0; cyc();
      lit("recover_warn", warn_prompt, 0);
      lit("recover_thr", tmr_threshold, 1500);

      time_out = 1; cyc(2);
      lit("stale_warn", warn_prompt, 1);
      cyc();
      lit("expired_pulse", session_expired, 1);
      lit("expire_cnt1", expire_count, 1);
      time_out = 0; cyc();
      lit("expired_once", session_expired, 0);
      lit("end_clr_n", tmr_clr_n, 0);
      cyc();
      lit("expire_idle", session_active, 0);

      start_session();
      time_out = 1; cyc(2);
      session_end = 1; cyc();
      lit("prio_no_expire", session_expired, 0);
      lit("prio_cnt", expire_count, 1);
      session_end = 0; time_out = 0; cyc();

      start_session();
      activity = 1; time_out = 1; cyc();
      lit("to_beats_act_rs", tmr_restart, 0);
      lit("to_beats_act_clr", tmr_clr_n, 0);
      activity = 0; time_out = 0; cyc();
      card_in = 0; cyc();
      lit("card_fall_warn", warn_prompt, 0);
      lit("card_fall_clr", tmr_clr_n, 0);
      cyc();

      start_session();
      card_in = 0; cyc();
      lit("removal_end", tmr_clr_n, 0);
      cyc();
      lit("removal_idle", session_active, 0);

      for (int i = 0; i < 256; i++) expire_once();
      lit("count_saturate", expire_count, 255);

      start_session();
      time_out = 1; cyc(2);
      time_out = 0;
      lit("pre_reset_warn", warn_prompt, 1);
      @(posedge clk); #2 rst = 0; #1;
      lit("rst_active", session_active, 0);
      lit("rst_clr_n", tmr_clr_n, 1);
      lit("rst_warn", warn_prompt, 0);
      lit("rst_cnt", expire_count, 0);
      cyc(2);
      rst = 1;
      cyc(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "bench did not finish");
   end

endmodule

// File: doc/atm_session_guard.md
Name: atm_session_guard

Overview:
- Session-level consumer of the timer interface. Drives the timer's start/restart/threshold inputs and its local clear, reacts to the timer's time_out flag, and turns it into user-facing session events.
- Sequence: card insertion arms the inactivity phase; keypad activity restarts it; an inactivity timeout raises a "more time?" warning phase; a warning timeout expires the session so the card can be ejected.
- Sits between the ATM main controller (card_in, activity, session_end) and one timer instance.

Parameters:
- INACT_CYC, 32'd1500, threshold loaded during the ACTIVE phase.
- WARN_CYC, 32'd500, threshold loaded during the WARN phase.
- CNT_W, 8, width of the saturating expiry counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- card_in  in  1  level, high while a card is inserted.
- activity  in  1  single-cycle pulse per keypress.
- session_end  in  1  single-cycle pulse; controller ends the session normally.
- time_out  in  1  timer flag; sticky until the timer is cleared.
- tmr_start  out  1  timer enable.
- tmr_restart  out  1  timer counter restart, one-cycle pulse.
- tmr_threshold  out  32  timer compare value.
- tmr_clr_n  out  1  active-low clear to the timer's reset input, one-cycle pulse.
- warn_prompt  out  1  high throughout the WARN state.
- session_active  out  1  high in ACTIVE, ARM_W and WARN.
- session_expired  out  1  one-cycle pulse on expiry.
- expire_count  out  CNT_W  number of expired sessions, saturating.

Behaviour:
- Reset values: state IDLE; tmr_start=0, tmr_restart=0, tmr_threshold=0, tmr_clr_n=1, warn_prompt=0, session_active=0, session_expired=0, expire_count=0.
- Output timing: all outputs registered (Moore), decoded from the state being entered.
- Card detection: card_in is sampled into a register; card_rise = card_in & ~card_q; card_fall = ~card_in & card_q.
- States: IDLE, ARM_A, ACTIVE, ARM_W, WARN, EXPIRE, END_CLR.
- IDLE: all outputs low except tmr_clr_n=1. card_rise -> ARM_A. card_in held high from reset does not start a session; a rising edge is required.
- ARM_A: tmr_clr_n=0, tmr_start=0, tmr_threshold=INACT_CYC. Always -> ACTIVE next cycle.
- ACTIVE: tmr_start=1, tmr_threshold=INACT_CYC, session_active=1.
  - Priority: (session_end | card_fall) -> END_CLR; else time_out -> ARM_W; else activity -> stay in ACTIVE with tmr_restart=1 in the next cycle only.
  - Back-to-back activity pulses give back-to-back restart pulses.
- ARM_W: tmr_clr_n=0, tmr_start=0, tmr_threshold=WARN_CYC, session_active=1. Always -> WARN.
- WARN: tmr_start=1, tmr_threshold=WARN_CYC, warn_prompt=1, session_active=1.
  - Priority: (session_end | card_fall) -> END_CLR; else time_out -> EXPIRE; else activity -> ARM_A (user accepted more time).
- EXPIRE: session_expired=1 for exactly one cycle; expire_count increments, holds at 2^CNT_W-1. -> END_CLR.
- END_CLR: tmr_clr_n=0, tmr_start=0, session_active=0. -> IDLE.
- time_out masking: time_out is sampled only in ACTIVE and WARN. It is ignored in every other state and in any cycle where registered tmr_clr_n is 0, because the sticky flag from the previous phase is being cleared.
- Latency:
  - time_out high in ACTIVE at cycle N -> tmr_clr_n low at N+1 -> warn_prompt high at N+2.
  - time_out high in WARN at N -> session_expired high at N+1 -> tmr_clr_n low at N+2 -> IDLE at N+3.
- Every timing phase entry passes through exactly one tmr_clr_n=0 cycle, so no stale time_out carries between phases.
- Simultaneous events: session_end with time_out in WARN -> END_CLR, no expiry pulse and no count. activity with time_out in ACTIVE -> ARM_W (timeout wins over activity).
- Reset mid-operation: immediate return to reset values and IDLE. expire_count is cleared.

Test Plan:
- Session start: reset, then card_in 0->1 -> ARM_A next cycle with tmr_clr_n=0, ACTIVE after that with tmr_start=1, tmr_threshold=1500, session_active=1.
- Activity restart: in ACTIVE, pulse activity for 3 consecutive cycles -> tmr_restart high for exactly 3 consecutive cycles, one cycle delayed; state stays ACTIVE.
- Warn then recover: in ACTIVE, time_out=1 -> tmr_clr_n=0 next cycle, then warn_prompt=1 and tmr_threshold=500. activity in WARN -> ARM_A then ACTIVE, warn_prompt=0, tmr_threshold=1500.
- Full expiry: time_out in ACTIVE, then in WARN -> session_expired one-cycle pulse, expire_count 0->1, END_CLR, IDLE. Force expire_count=255 and expire again -> count stays 255.
- Priority and stale flag: in WARN, session_end and time_out asserted in the same cycle -> END_CLR, no session_expired. Hold time_out high through ARM_W -> it is ignored there and sampled again only once in WARN.
- Card removal and reset: card_in falls in ACTIVE -> END_CLR then IDLE. Assert rst low in WARN -> all outputs at reset values the same cycle; session_active=0, tmr_clr_n=1.
